seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 206 ++++++++++++++++++++
 tb/tb_seq_detect_param.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param
// Serial bit-pattern detector. The pattern, its length (1..PAT_W) and the
// overlap mode can be reloaded at run time through a one-cycle cfg_load
// strobe. Each match gives a one-cycle registered pulse on dout and bumps a
// saturating counter. A rejected configuration raises a sticky cfg_err flag.
module seq_detect_param #(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0000_1001),
    parameter int               DEF_LEN = 4,
    parameter bit               DEF_OVL = 1'b1,
    localparam int              LEN_W   = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err,
    output logic [1:0]       state
);

    // Encoding is visible on the state port, so values are fixed explicitly.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        HUNT = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q,   pat_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic               ovl_q,   ovl_d;
    logic [PAT_W-1:0]   hist_q,  hist_d;
    logic [LEN_W-1:0]   fill_q,  fill_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               dout_q,  dout_d;
    logic               err_q,   err_d;

    // ------------------------------------------------------------------
    // Input qualification
    // ------------------------------------------------------------------
    logic accept;       // a data bit enters the history this cycle
    logic cfg_legal;    // cfg_load with a length in 1..PAT_W
    logic cfg_bad;      // cfg_load with length 0 or above PAT_W

    // A bit arriving together with a configuration strobe is dropped, so a
    // new pattern never sees a bit that belonged to the old one.
    assign accept    = din_valid & en & ~cfg_load;
    assign cfg_legal = cfg_load && (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    assign cfg_bad   = cfg_load && !cfg_legal;

    // ------------------------------------------------------------------
    // History datapath
    // ------------------------------------------------------------------
    logic [PAT_W-1:0] hist_base;   // history the incoming bit shifts into
    logic [LEN_W-1:0] fill_base;   // valid-bit count matching hist_base
    logic [PAT_W-1:0] hist_shift;  // history including the accepted bit
    logic [LEN_W-1:0] fill_inc;    // fill after the accepted bit, saturated
    logic [PAT_W-1:0] len_mask;    // ones in bit positions [len-1:0]
    logic             fill_ok;     // enough bits received to compare
    logic             hit;         // match on this cycle's accepted bit

    // Leaving IDLE starts from an empty history; elsewhere the stored one.
    assign hist_base  = (state_q == IDLE) ? '0 : hist_q;
    assign fill_base  = (state_q == IDLE) ? '0 : fill_q;
    assign hist_shift = {hist_base[PAT_W-2:0], din};
    assign fill_inc   = (fill_base == LEN_W'(PAT_W)) ? fill_base
                                                     : fill_base + LEN_W'(1);

    // Build a mask selecting the active pattern bits for the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    // Widened by one bit so fill+1 cannot wrap when fill equals PAT_W.
    assign fill_ok = ({1'b0, fill_base} + (LEN_W+1)'(1)) >= {1'b0, len_q};
    assign hit     = accept && fill_ok
                     && (((hist_shift ^ pat_q) & len_mask) == '0);

    // ------------------------------------------------------------------
    // Configuration and history next-state
    // ------------------------------------------------------------------
    // Load a legal configuration, otherwise shift accepted bits into the
    // history; disabling, reloading or a non-overlapping match empties it.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;

        if (cfg_legal) begin
            pat_d  = cfg_pat;
            len_d  = cfg_len;
            ovl_d  = cfg_ovl;
            hist_d = '0;
            fill_d = '0;
        end else if (!en) begin
            // Entering or sitting in IDLE discards any partial history.
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            if (hit && !ovl_q) begin
                // Consume the matched bits so none can start another match.
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_shift;
                fill_d = fill_inc;
            end
        end else begin
            // No new bit: keep the history, cleared if just leaving IDLE.
            hist_d = hist_base;
            fill_d = fill_base;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state
    // ------------------------------------------------------------------
    // IDLE while disabled, FILL while the history is shorter than len-1,
    // HUNT once the next accepted bit can complete a match.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else if (cfg_legal) begin
            state_d = FILL;
        end else if (({1'b0, fill_d} + (LEN_W+1)'(1)) >= {1'b0, len_d}) begin
            state_d = HUNT;
        end else begin
            state_d = FILL;
        end
    end

    // ------------------------------------------------------------------
    // Match pulse, counter and error flag next-state
    // ------------------------------------------------------------------
    // Count matches with saturation; a clear or a new configuration wins
    // over a coincident match, though the dout pulse is still produced.
    always_comb begin
        dout_d = hit;
        err_d  = err_q | cfg_bad;
        cnt_d  = cnt_q;
        if (cfg_legal || cnt_clr) begin
            cnt_d = '0;
        end else if (hit && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // Register all state; reset restores the default configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= DEF_PAT;
            len_q   <= LEN_W'(DEF_LEN);
            ovl_q   <= DEF_OVL;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dout      = dout_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param
// Directed stimulus for seq_detect_param with a queue-based reference model
// checked on every falling edge, plus literal expectations at key points.
module tb_seq_detect_param;

    localparam int PAT_W    = 8;
    localparam int CNT_W    = 8;
    localparam int LEN_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             din;
    logic             din_valid;
    logic             en;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic             cnt_clr;
    logic             dout;
    logic [CNT_W-1:0] match_cnt;
    logic             cfg_err;
    logic [1:0]       state;

    seq_detect_param #(
        .PAT_W   (PAT_W),
        .CNT_W   (CNT_W),
        .DEF_PAT (8'b0000_1001),
        .DEF_LEN (4),
        .DEF_OVL (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .en        (en),
        .cfg_load  (cfg_load),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .cfg_ovl   (cfg_ovl),
        .cnt_clr   (cnt_clr),
        .dout      (dout),
        .match_cnt (match_cnt),
        .cfg_err   (cfg_err),
        .state     (state)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the history is the list of bits received since the
    // last clear; a match means its tail equals the pattern, read with the
    // first-received bit at pat[len-1].
    // ------------------------------------------------------------------
    logic [PAT_W-1:0] m_pat   = 8'b0000_1001;
    int               m_len   = 4;
    logic             m_ovl   = 1'b1;
    bit               hq[$];
    int               m_cnt   = 0;
    logic             m_err   = 1'b0;
    logic             m_dout  = 1'b0;
    logic [1:0]       m_state = 2'b00;

    // Inputs as seen by the DUT at the last rising edge.
    logic             s_live = 1'b0;
    logic             s_din, s_valid, s_en, s_load, s_ovl, s_clr;
    logic [PAT_W-1:0] s_pat;
    logic [LEN_W-1:0] s_len;

    always @(posedge clk) begin
        s_live  <= !rst;
        s_din   <= din;
        s_valid <= din_valid;
        s_en    <= en;
        s_load  <= cfg_load;
        s_pat   <= cfg_pat;
        s_len   <= cfg_len;
        s_ovl   <= cfg_ovl;
        s_clr   <= cnt_clr;
    end

    task automatic model_reset();
        m_pat   = 8'b0000_1001;
        m_len   = 4;
        m_ovl   = 1'b1;
        hq.delete();
        m_cnt   = 0;
        m_err   = 1'b0;
        m_dout  = 1'b0;
        m_state = 2'b00;
    endtask

    task automatic model_step();
        bit acc;
        bit legal;
        bit hit;
        acc   = s_valid && s_en && !s_load;
        legal = s_load && (s_len != 0) && (int'(s_len) <= PAT_W);
        hit   = 1'b0;
        if (legal) begin
            m_pat = s_pat;
            m_len = int'(s_len);
            m_ovl = s_ovl;
            hq.delete();
        end else if (s_load) begin
            m_err = 1'b1;
        end
        if (!s_en) begin
            hq.delete();
        end else if (acc) begin
            hq.push_back(s_din);
            if (hq.size() > PAT_W) void'(hq.pop_front());
            if (hq.size() >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (hq[hq.size() - 1 - i] != m_pat[i]) hit = 1'b0;
            end
            if (hit && !m_ovl) hq.delete();
        end
        if (legal || s_clr)             m_cnt = 0;
        else if (hit && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        m_dout = hit;
        if (!s_en)                         m_state = 2'b00;
        else if (legal)                    m_state = 2'b01;
        else if (hq.size() < m_len - 1)    m_state = 2'b01;
        else                               m_state = 2'b10;
    endtask

    // Compare process: advance the model, then check every output.
    always @(negedge clk) begin
        if (rst)         model_reset();
        else if (s_live) model_step();
        check("cyc dout",      {31'd0, dout},     {31'd0, m_dout});
        check("cyc match_cnt", 32'(match_cnt),    32'(m_cnt));
        check("cyc cfg_err",   {31'd0, cfg_err},  {31'd0, m_err});
        check("cyc state",     {30'd0, state},    {30'd0, m_state});
        if (!rst && dout) pulses++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc(input logic v, input logic d, input logic e, input logic clr);
        din_valid = v;
        din       = d;
        en        = e;
        cnt_clr   = clr;
        @(posedge clk);
        #1;
        cnt_clr   = 1'b0;
    endtask

    task automatic bit_in(input logic d);
        cyc(1'b1, d, 1'b1, 1'b0);
    endtask

    task automatic gap();
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Sends the n low bits of v, most significant first.
    task automatic send(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
    endtask

    // Configuration strobe; a valid 1 is presented alongside and must be lost.
    task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                        input logic o);
        cfg_pat   = p;
        cfg_len   = l;
        cfg_ovl   = o;
        cfg_load  = 1'b1;
        din_valid = 1'b1;
        din       = 1'b1;
        en        = 1'b1;
        @(posedge clk);
        #1;
        cfg_load  = 1'b0;
        din_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int p0;

    initial begin
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; en = 1'b0; cfg_load = 1'b0;
        cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset dout",      {31'd0, dout},    32'd0);
        check("reset match_cnt", 32'(match_cnt),   32'd0);
        check("reset cfg_err",   {31'd0, cfg_err}, 32'd0);
        check("reset state",     {30'd0, state},   32'd0);
        rst = 1'b0;

        // Default 1001, overlap on: stream 1001001 matches twice.
        p0 = pulses;
        send(32'b1001, 4);
        check("dflt pulse bit4", {31'd0, dout}, 32'd1);
        send(32'b001, 3);
        check("dflt pulse bit7", {31'd0, dout}, 32'd1);
        gap();
        check("dflt match_cnt", 32'(match_cnt), 32'd2);
        check("dflt model cnt", 32'(m_cnt),     32'd2);
        check("dflt pulses",    32'(pulses - p0), 32'd2);

        // Non-overlap 1001: only the first match, then back to FILL.
        load(8'b0000_1001, 4'd4, 1'b0);
        check("load state fill", {30'd0, state}, 32'd1);
        p0 = pulses;
        send(32'b1001, 4);
        check("novl pulse bit4", {31'd0, dout},  32'd1);
        check("novl state fill", {30'd0, state}, 32'd1);
        send(32'b001, 3);
        gap();
        check("novl match_cnt", 32'(match_cnt), 32'd1);
        check("novl pulses",    32'(pulses - p0), 32'd1);

        // Illegal lengths 0 and 9: sticky error, old configuration kept.
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        load(8'hFF, 4'd0, 1'b1);
        check("len0 cfg_err", {31'd0, cfg_err}, 32'd1);
        load(8'hFF, 4'd9, 1'b1);
        check("len9 cfg_err",   {31'd0, cfg_err}, 32'd1);
        check("len9 cnt kept",  32'(match_cnt),   32'd1);
        p0 = pulses;
        send(32'b1001, 4);
        gap();
        check("old cfg pulses",    32'(pulses - p0), 32'd1);
        check("old cfg match_cnt", 32'(match_cnt),   32'd2);

        // len=1, pat=1, non-overlap: 300 ones saturate the counter.
        load(8'h01, 4'd1, 1'b0);
        p0 = pulses;
        for (int i = 0; i < 300; i++) bit_in(1'b1);
        check("len1 dout high", {31'd0, dout}, 32'd1);
        bit_in(1'b0);
        gap();
        check("sat match_cnt", 32'(match_cnt), 32'd255);
        check("sat model cnt", 32'(m_cnt),     32'd255);
        check("len1 pulses",   32'(pulses - p0), 32'd300);

        // len=1, pat=0, overlap: zeros match; then clear vs. match.
        load(8'h00, 4'd1, 1'b1);
        send(32'b010, 3);
        gap();
        check("len1 ovl cnt", 32'(match_cnt), 32'd2);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        check("clr+match dout", {31'd0, dout},  32'd1);
        check("clr+match cnt",  32'(match_cnt), 32'd0);

        // Reset mid-stream after 1,0,0, then 1; then 1,0,0,1 with gaps.
        load(8'b0000_1001, 4'd4, 1'b1);
        send(32'b100, 3);
        #2 rst = 1'b1;
        #1;
        check("async rst state", {30'd0, state},   32'd0);
        check("async rst err",   {31'd0, cfg_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        p0 = pulses;
        bit_in(1'b1);
        check("post rst no pulse", {31'd0, dout}, 32'd0);
        bit_in(1'b1);
        gap();
        bit_in(1'b0);
        gap();
        gap();
        bit_in(1'b0);
        bit_in(1'b1);
        check("post rst pulse", {31'd0, dout}, 32'd1);
        gap();
        check("post rst pulses", 32'(pulses - p0), 32'd1);

        // Disable mid-pattern: history is dropped.
        send(32'b100, 3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        bit_in(1'b1);
        check("en0 drop no pulse", {31'd0, dout}, 32'd0);
        repeat (3) gap();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
